// File: rtl/ring_digit_sequencer_pkg.sv
// Shared types, segment constants and Johnson decode for the ring display.
// Consumers: johnson_to_seg and ring_digit_sequencer.
package ring_disp_pkg;

    typedef enum logic [1:0] {
        S_GAP = 2'd0,
        S_H   = 2'd1,
        S_T   = 2'd2,
        S_O   = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam int         DP_BIT    = 7;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } jdec_t;

    function automatic jdec_t johnson_decode(input logic [4:0] code);
        jdec_t r;
        r.valid = 1'b1;
        r.digit = 4'd0;
        case (code)
            5'b00000: r.digit = 4'd0;
            5'b00001: r.digit = 4'd1;
            5'b00011: r.digit = 4'd2;
            5'b00111: r.digit = 4'd3;
            5'b01111: r.digit = 4'd4;
            5'b11111: r.digit = 4'd5;
            5'b11110: r.digit = 4'd6;
            5'b11100: r.digit = 4'd7;
            5'b11000: r.digit = 4'd8;
            5'b10000: r.digit = 4'd9;
            default:  r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ring_digit_sequencer_if.sv
// Digit triple in, multiplexed segment display out.
// master = producer/observer side, slave = sequencer side.
interface ring_digit_sequencer_if;
    logic [4:0] i_100;
    logic [4:0] i_010;
    logic [4:0] i_001;
    logic       i_hold;
    logic [7:0] o_led;
    logic       o_frame;
    logic [1:0] o_idx;

    modport master (
        output i_100, i_010, i_001, i_hold,
        input  o_led, o_frame, o_idx
    );

    modport slave (
        input  i_100, i_010, i_001, i_hold,
        output o_led, o_frame, o_idx
    );
endinterface

// File: rtl/ring_digit_sequencer_johnson_to_seg.sv
// Johnson code to 7-segment pattern; illegal codes always show "E",
// a blank request only suppresses legal digits.
module johnson_to_seg
    import ring_disp_pkg::*;
(
    input  logic [4:0] code,
    input  logic       blank,
    output logic [6:0] seg
);
    jdec_t dec;

    assign dec = johnson_decode(code);

    always_comb begin
        seg = SEG_E;
        if (dec.valid) begin
            seg = blank ? SEG_BLANK : digit_seg(dec.digit);
        end
    end
endmodule

// File: rtl/ring_digit_sequencer.sv
// Frame sequencer: GAP -> H -> T -> O, snapshot taken at frame start.
// Define RING_DIGIT_LZB_EN for leading-zero blanking.
module ring_digit_sequencer
    import ring_disp_pkg::*;
#(
    parameter int pDWELL = 1000,
    parameter int pGAP   = 250
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ring_digit_sequencer_if.slave bus
);
    localparam int MAXC = (pDWELL > pGAP) ? pDWELL : pGAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(pDWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(pGAP - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [4:0]      snap_h;
    logic [4:0]      snap_t;
    logic [4:0]      snap_o;
    logic [4:0]      code;
    logic            blank;
    logic [6:0]      seg;
    logic [7:0]      led_q;
    logic            frame_q;

    assign last = (state == S_GAP) ? (cnt == GAP_LAST)
                                   : (cnt == DWELL_LAST);

    always_comb begin
        state_nx = S_GAP;
        unique case (state)
            S_GAP: state_nx = S_H;
            S_H:   state_nx = S_T;
            S_T:   state_nx = S_O;
            S_O:   state_nx = S_GAP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_GAP;
            cnt     <= '0;
            snap_h  <= '0;
            snap_t  <= '0;
            snap_o  <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= last && (state == S_GAP);
            if (last) begin
                state <= state_nx;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Frame-start snapshot keeps all three digits self-consistent
            if (last && (state == S_GAP) && !bus.i_hold) begin
                snap_h <= bus.i_100;
                snap_t <= bus.i_010;
                snap_o <= bus.i_001;
            end
        end
    end

    always_comb begin
        code = snap_o;
        unique case (state)
            S_H:     code = snap_h;
            S_T:     code = snap_t;
            default: code = snap_o;
        endcase
    end

`ifdef RING_DIGIT_LZB_EN
    jdec_t dec_h;
    jdec_t dec_t;
    logic  h_zero;
    logic  t_zero;

    assign dec_h  = johnson_decode(snap_h);
    assign dec_t  = johnson_decode(snap_t);
    assign h_zero = dec_h.valid && (dec_h.digit == 4'd0);
    assign t_zero = dec_t.valid && (dec_t.digit == 4'd0);
    assign blank  = ((state == S_H) && h_zero)
                 || ((state == S_T) && h_zero && t_zero);
`else
    assign blank = 1'b0;
`endif

    johnson_to_seg u_seg (
        .code  (code),
        .blank (blank),
        .seg   (seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_q <= 8'h00;
        end else begin
            unique case (state)
                S_GAP:   led_q <= 8'h00;
                S_O:     led_q <= {1'b1, seg};
                default: led_q <= {1'b0, seg};
            endcase
        end
    end

    assign bus.o_led   = led_q;
    assign bus.o_frame = frame_q;
    assign bus.o_idx   = state;
endmodule
